// File: rtl/vc_inport_receiver_pkg.sv
// -----------------------------------------------------------------------------
// vc_inport_pkg
// Shared definitions for the VC input-port receiver:
//   - default parameter values of the receiver
//   - per-VC FIFO depth (d, in phits) and occupancy-count width (c)
//   - stored-entry layout {is_new, data}
//   - per-VC framing state encoding (IDLE / PKT)
// -----------------------------------------------------------------------------
package vc_inport_pkg;

  localparam int no_vc_dflt                       = 13;
  localparam int floorplusone_log2_no_vc_dflt     = 4;
  localparam int flit_size_dflt                   = 1;
  localparam int floorplusone_log2_flit_size_dflt = 1;
  localparam int phit_size_dflt                   = 16;
  localparam int buf_size_dflt                    = 4;
  localparam int floorplusone_log2_buf_size_dflt  = 3;
  localparam int addr_length_dflt                 = 10;
  localparam int addr_place_in_header_dflt        = 0;

  // FIFO depth in phits and width of the occupancy count for the defaults.
  localparam int d = buf_size_dflt * flit_size_dflt;
  localparam int c = floorplusone_log2_buf_size_dflt + floorplusone_log2_flit_size_dflt;

  // Per-VC framing state: IDLE until a header is accepted, then PKT.
  localparam logic st_idle = 1'b0;
  localparam logic st_pkt  = 1'b1;

  // Stored FIFO entry: header marker in the MSB, phit payload below it.
  typedef struct packed {
    logic                      is_new;
    logic [phit_size_dflt-1:0] data;
  } entry_t;

endpackage

// File: rtl/vc_inport_receiver_if.sv
// -----------------------------------------------------------------------------
// vc_inport_receiver_if
// Phit link between a fork/router outport (master) and a VC input-port
// receiver (slave).
//   link_data_in      master->slave  phit payload
//   link_sent_req_in  master->slave  phit valid
//   link_new_in       master->slave  phit is a packet header
//   link_vc_no_in     master->slave  target virtual channel
//   link_ready_out    slave->master  target VC can accept this cycle
// -----------------------------------------------------------------------------
interface vc_inport_receiver_if #(
  parameter int phit_size               = 16,
  parameter int floorplusone_log2_no_vc = 4
);

  logic [phit_size-1:0]               link_data_in;
  logic                               link_sent_req_in;
  logic                               link_new_in;
  logic [floorplusone_log2_no_vc-1:0] link_vc_no_in;
  logic                               link_ready_out;

  modport master (
    output link_data_in, link_sent_req_in, link_new_in, link_vc_no_in,
    input  link_ready_out
  );

  modport slave (
    input  link_data_in, link_sent_req_in, link_new_in, link_vc_no_in,
    output link_ready_out
  );

endinterface

// File: rtl/vc_inport_receiver_phit_fifo.sv
// -----------------------------------------------------------------------------
// phit_fifo
// Circular FIFO of one virtual channel. Head entry is visible combinationally.
//   clk    in   clock, rising edge
//   rs     in   asynchronous active-high reset (pointers and count only)
//   push   in   write wdata at the tail (ignored when full)
//   pop    in   remove the head (ignored when empty)
//   wdata  in   entry to write
//   rdata  out  head entry (undefined while empty)
//   count  out  number of stored entries, 0..depth
// -----------------------------------------------------------------------------
module phit_fifo #(
  parameter int depth   = 4,
  parameter int width   = 17,
  parameter int count_w = 4
) (
  input  logic               clk,
  input  logic               rs,
  input  logic               push,
  input  logic               pop,
  input  logic [width-1:0]   wdata,
  output logic [width-1:0]   rdata,
  output logic [count_w-1:0] count
);

  localparam int ptr_w = (depth > 1) ? $clog2(depth) : 1;

  logic [width-1:0] mem [depth];
  logic [ptr_w-1:0] wr_ptr;
  logic [ptr_w-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] ptr);
    return (ptr == ptr_w'(depth - 1)) ? '0 : ptr + ptr_w'(1);
  endfunction

  assign do_push = push && (count != count_w'(depth));
  assign do_pop  = pop  && (count != '0);
  assign rdata   = mem[rd_ptr];

  // NOTE: storage array carries no reset; emptiness is tracked by count alone,
  // and consumers gate the head with their own valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + count_w'(1);
        2'b01:   count <= count - count_w'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vc_inport_receiver.sv
// -----------------------------------------------------------------------------
// vc_inport_receiver
// Receiving end of a phit link below a fork finger. One FIFO per VC, framing
// and destination checks on the write side, VC-selectable read port.
//   clk               in   clock, rising edge
//   rs                in   asynchronous active-high reset
//   link              slave side of the phit link (data/req/new/vc, ready)
//   rd_vc_in          in   VC selected for reading
//   rd_en_in          in   pop head of the selected VC
//   rd_data_out       out  head phit of the selected VC (0 if none)
//   rd_new_out        out  head phit is a header
//   rd_valid_out      out  selected VC exists and is non-empty
//   nonempty_vec_out  out  per-VC non-empty flags
//   my_addr           in   this node's address
//   misroute_out      out  sticky: a header carried another address
//   proto_err_out     out  sticky: framing violation seen
//   busy              out  any VC non-empty or any VC mid-flit
// -----------------------------------------------------------------------------
module vc_inport_receiver
  import vc_inport_pkg::*;
#(
  parameter int no_vc                       = no_vc_dflt,
  parameter int floorplusone_log2_no_vc     = floorplusone_log2_no_vc_dflt,
  parameter int flit_size                   = flit_size_dflt,
  parameter int floorplusone_log2_flit_size = floorplusone_log2_flit_size_dflt,
  parameter int phit_size                   = phit_size_dflt,
  parameter int buf_size                    = buf_size_dflt,
  parameter int floorplusone_log2_buf_size  = floorplusone_log2_buf_size_dflt,
  parameter int addr_length                 = addr_length_dflt,
  parameter int addr_place_in_header        = addr_place_in_header_dflt
) (
  input  logic                               clk,
  input  logic                               rs,
  vc_inport_receiver_if.slave                link,
  input  logic [floorplusone_log2_no_vc-1:0] rd_vc_in,
  input  logic                               rd_en_in,
  output logic [phit_size-1:0]               rd_data_out,
  output logic                               rd_new_out,
  output logic                               rd_valid_out,
  output logic [no_vc-1:0]                   nonempty_vec_out,
  input  logic [addr_length-1:0]             my_addr,
  output logic                               misroute_out,
  output logic                               proto_err_out,
  output logic                               busy
);

  localparam int depth   = buf_size * flit_size;
  localparam int cnt_w   = floorplusone_log2_buf_size + floorplusone_log2_flit_size;
  localparam int vc_w    = floorplusone_log2_no_vc;
  localparam int p_w     = floorplusone_log2_flit_size;
  localparam int entry_w = phit_size + 1;

  // Per-VC storage and framing state.
  logic [cnt_w-1:0]   count    [no_vc];
  logic [entry_w-1:0] head     [no_vc];
  logic [p_w-1:0]     p        [no_vc];
  logic               vc_state [no_vc];
  logic [no_vc-1:0]   full_vec;
  logic [no_vc-1:0]   push_vec;
  logic [no_vc-1:0]   pop_vec;
  logic [no_vc-1:0]   mid_flit_vec;

  // Write-side decode.
  logic               wr_vc_ok;
  logic [vc_w-1:0]    wr_idx;
  logic [p_w-1:0]     cur_p;
  logic               cur_state;
  logic               accept;
  logic               hdr_bad;
  logic               body_bad;
  logic               store;
  logic               addr_mismatch;

  // Read-side decode.
  logic               rd_vc_ok;
  logic [vc_w-1:0]    rd_idx;
  logic [entry_w-1:0] rd_head;

  function automatic logic [p_w-1:0] p_inc(input logic [p_w-1:0] v);
    return (v == p_w'(flit_size - 1)) ? '0 : v + p_w'(1);
  endfunction

  // Out-of-range VC numbers are steered to index 0 so no array read goes
  // out of bounds; the *_ok qualifiers keep them from having any effect.
  assign wr_vc_ok  = link.link_vc_no_in < vc_w'(no_vc);
  assign wr_idx    = wr_vc_ok ? link.link_vc_no_in : '0;
  assign cur_p     = p[wr_idx];
  assign cur_state = vc_state[wr_idx];

  // Readiness depends only on registered counts, never on a same-cycle pop.
  assign link.link_ready_out = wr_vc_ok && !full_vec[wr_idx];
  assign accept              = link.link_sent_req_in && link.link_ready_out;

  // A header must start a flit; a body phit needs an open packet. Offending
  // phits are still handshaken but never written.
  assign hdr_bad  = link.link_new_in && (cur_p != '0);
  assign body_bad = !link.link_new_in && (cur_state == st_idle);
  assign store    = accept && !hdr_bad && !body_bad;

  assign addr_mismatch =
    link.link_data_in[addr_place_in_header +: addr_length] != my_addr;

  genvar v;
  generate
    for (v = 0; v < no_vc; v++) begin : g_vc
      assign push_vec[v]         = store && (wr_idx == vc_w'(v));
      assign pop_vec[v]          = rd_en_in && rd_valid_out && (rd_idx == vc_w'(v));
      assign full_vec[v]         = count[v] == cnt_w'(depth);
      assign nonempty_vec_out[v] = count[v] != '0;
      assign mid_flit_vec[v]     = p[v] != '0;

      phit_fifo #(
        .depth   (depth),
        .width   (entry_w),
        .count_w (cnt_w)
      ) u_fifo (
        .clk   (clk),
        .rs    (rs),
        .push  (push_vec[v]),
        .pop   (pop_vec[v]),
        .wdata ({link.link_new_in, link.link_data_in}),
        .rdata (head[v]),
        .count (count[v])
      );
    end
  endgenerate

  // Flit-position counter and packet state of the addressed VC. A body phit
  // arriving in IDLE is the only accepted phit that does not advance p.
  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      for (int i = 0; i < no_vc; i++) begin
        p[i]        <= '0;
        vc_state[i] <= st_idle;
      end
    end else if (accept) begin
      if (!body_bad) p[wr_idx] <= p_inc(cur_p);
      if (link.link_new_in && !hdr_bad) vc_state[wr_idx] <= st_pkt;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      misroute_out  <= 1'b0;
      proto_err_out <= 1'b0;
    end else begin
      if (accept && (hdr_bad || body_bad))
        proto_err_out <= 1'b1;
      if (store && link.link_new_in && addr_mismatch)
        misroute_out <= 1'b1;
    end
  end

  assign rd_vc_ok     = rd_vc_in < vc_w'(no_vc);
  assign rd_idx       = rd_vc_ok ? rd_vc_in : '0;
  assign rd_valid_out = rd_vc_ok && nonempty_vec_out[rd_idx];

  // NOTE: every output of a combinational block gets a default first, so no
  // path through it can leave a value held and infer a latch.
  always_comb begin
    rd_head     = '0;
    rd_data_out = '0;
    rd_new_out  = 1'b0;
    if (rd_valid_out) begin
      rd_head     = head[rd_idx];
      rd_data_out = rd_head[phit_size-1:0];
      rd_new_out  = rd_head[phit_size];
    end
  end

  assign busy = (|nonempty_vec_out) || (|mid_flit_vec);

endmodule

// File: tb/tb_vc_inport_receiver.sv
module tb_vc_inport_receiver;

  logic        clk = 1'b0;
  logic        rs, rs2;
  int          vectors = 0;
  int          errors  = 0;

  // DUT 1: default parameters (flit_size=1, depth 4).
  logic [3:0]  rd_vc;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        rd_new, rd_valid;
  logic [12:0] nonempty;
  logic [9:0]  my_addr;
  logic        misroute, proto_err, busy;

  // DUT 2: flit_size=2 for framing checks.
  logic [3:0]  rd_vc2;
  logic        rd_en2;
  logic [15:0] rd_data2;
  logic        rd_new2, rd_valid2;
  logic [12:0] nonempty2;
  logic [9:0]  my_addr2;
  logic        misroute2, proto_err2, busy2;

  vc_inport_receiver_if #(.phit_size(16), .floorplusone_log2_no_vc(4)) l1 ();
  vc_inport_receiver_if #(.phit_size(16), .floorplusone_log2_no_vc(4)) l2 ();

  always #5 clk = ~clk;

  vc_inport_receiver dut (
    .clk(clk), .rs(rs), .link(l1.slave),
    .rd_vc_in(rd_vc), .rd_en_in(rd_en), .rd_data_out(rd_data),
    .rd_new_out(rd_new), .rd_valid_out(rd_valid), .nonempty_vec_out(nonempty),
    .my_addr(my_addr), .misroute_out(misroute), .proto_err_out(proto_err),
    .busy(busy)
  );

  vc_inport_receiver #(.flit_size(2), .floorplusone_log2_flit_size(2)) dut2 (
    .clk(clk), .rs(rs2), .link(l2.slave),
    .rd_vc_in(rd_vc2), .rd_en_in(rd_en2), .rd_data_out(rd_data2),
    .rd_new_out(rd_new2), .rd_valid_out(rd_valid2), .nonempty_vec_out(nonempty2),
    .my_addr(my_addr2), .misroute_out(misroute2), .proto_err_out(proto_err2),
    .busy(busy2)
  );

  task automatic send1(input logic [15:0] d, input logic n, input logic [3:0] vc);
    @(negedge clk);
    l1.link_data_in = d; l1.link_new_in = n; l1.link_vc_no_in = vc;
    l1.link_sent_req_in = 1'b1;
    @(posedge clk); #1;
    l1.link_sent_req_in = 1'b0;
  endtask

  task automatic pop1(input logic [3:0] vc);
    @(negedge clk);
    rd_vc = vc; rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  task automatic send2(input logic [15:0] d, input logic n, input logic [3:0] vc);
    @(negedge clk);
    l2.link_data_in = d; l2.link_new_in = n; l2.link_vc_no_in = vc;
    l2.link_sent_req_in = 1'b1;
    @(posedge clk); #1;
    l2.link_sent_req_in = 1'b0;
  endtask

  task automatic pop2(input logic [3:0] vc);
    @(negedge clk);
    rd_vc2 = vc; rd_en2 = 1'b1;
    @(posedge clk); #1;
    rd_en2 = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #3;
    rs = 1'b1; l1.link_vc_no_in = 4'd0; rd_vc = 4'd0;
    #1;
    vectors++; if (nonempty !== 13'h0) begin errors++; $display("FAIL reset_nonempty: got %h want 0000", nonempty); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (l1.link_ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", l1.link_ready_out); end
    vectors++; if ({misroute, proto_err} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {misroute, proto_err}); end
    vectors++; if ({rd_valid, rd_new, rd_data} !== 18'h0) begin errors++; $display("FAIL reset_rd: got %h want 0", {rd_valid, rd_new, rd_data}); end
    @(negedge clk); rs = 1'b0;
  endtask

  task automatic test_fill();
    my_addr = 10'd5;
    send1(16'h0005, 1'b1, 4'd3);
    send1(16'h1111, 1'b0, 4'd3);
    send1(16'h2222, 1'b0, 4'd3);
    send1(16'h3333, 1'b0, 4'd3);
    vectors++; if (nonempty !== 13'h0008) begin errors++; $display("FAIL fill_nonempty: got %h want 0008", nonempty); end
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL fill_busy: got %b want 1", busy); end
    vectors++; if (misroute !== 1'b0) begin errors++; $display("FAIL fill_misroute: got %b want 0", misroute); end
    @(negedge clk); l1.link_vc_no_in = 4'd3; #1;
    vectors++; if (l1.link_ready_out !== 1'b0) begin errors++; $display("FAIL fill_ready_vc3: got %b want 0", l1.link_ready_out); end
    l1.link_vc_no_in = 4'd4; #1;
    vectors++; if (l1.link_ready_out !== 1'b1) begin errors++; $display("FAIL fill_ready_vc4: got %b want 1", l1.link_ready_out); end
    // 5th phit held on the full VC across an edge: must not be taken.
    l1.link_vc_no_in = 4'd3; l1.link_data_in = 16'h4444; l1.link_new_in = 1'b0;
    l1.link_sent_req_in = 1'b1; rd_vc = 4'd3;
    @(posedge clk); #1;
    vectors++; if (l1.link_ready_out !== 1'b0) begin errors++; $display("FAIL fill_hold_ready: got %b want 0", l1.link_ready_out); end
    vectors++; if ({rd_new, rd_data} !== {1'b1, 16'h0005}) begin errors++; $display("FAIL fill_head: got %h want 10005", {rd_new, rd_data}); end
  endtask

  task automatic test_drain();
    // 5th phit still offered; popping frees a slot for it.
    @(negedge clk); rd_vc = 4'd3; rd_en = 1'b1;
    @(posedge clk); #1;
    vectors++; if ({rd_new, rd_data} !== {1'b0, 16'h1111}) begin errors++; $display("FAIL drain_1111: got %h want 01111", {rd_new, rd_data}); end
    vectors++; if (l1.link_ready_out !== 1'b1) begin errors++; $display("FAIL drain_ready_back: got %b want 1", l1.link_ready_out); end
    // Next edge pushes 0x4444 and pops 0x1111 together.
    @(posedge clk); #1;
    l1.link_sent_req_in = 1'b0;
    vectors++; if ({rd_new, rd_data} !== {1'b0, 16'h2222}) begin errors++; $display("FAIL drain_2222: got %h want 02222", {rd_new, rd_data}); end
    @(posedge clk); #1;
    vectors++; if ({rd_new, rd_data} !== {1'b0, 16'h3333}) begin errors++; $display("FAIL drain_3333: got %h want 03333", {rd_new, rd_data}); end
    @(posedge clk); #1;
    vectors++; if ({rd_valid, rd_new, rd_data} !== {2'b10, 16'h4444}) begin errors++; $display("FAIL drain_4444: got %h want 24444", {rd_valid, rd_new, rd_data}); end
    @(posedge clk); #1;
    rd_en = 1'b0;
    vectors++; if ({rd_valid, rd_data} !== 17'h0) begin errors++; $display("FAIL drain_empty_rd: got %h want 0", {rd_valid, rd_data}); end
    vectors++; if ({nonempty, busy} !== 14'h0) begin errors++; $display("FAIL drain_empty_vec: got %h want 0", {nonempty, busy}); end
  endtask

  task automatic test_misroute();
    send1(16'h0007, 1'b1, 4'd1);
    vectors++; if ({misroute, proto_err} !== 2'b10) begin errors++; $display("FAIL misroute_set: got %b want 10", {misroute, proto_err}); end
    @(negedge clk); rd_vc = 4'd1; #1;
    vectors++; if ({rd_valid, rd_new, rd_data} !== {2'b11, 16'h0007}) begin errors++; $display("FAIL misroute_stored: got %h want 30007", {rd_valid, rd_new, rd_data}); end
    pop1(4'd1);
    vectors++; if ({misroute, nonempty} !== {1'b1, 13'h0}) begin errors++; $display("FAIL misroute_sticky: got %h want 1 and empty", {misroute, nonempty}); end
  endtask

  task automatic test_framing();
    send2(16'hAAAA, 1'b0, 4'd2);
    vectors++; if (proto_err2 !== 1'b1) begin errors++; $display("FAIL frame_idle_body_err: got %b want 1", proto_err2); end
    vectors++; if ({nonempty2, busy2} !== 14'h0) begin errors++; $display("FAIL frame_idle_body_drop: got %h want 0", {nonempty2, busy2}); end
    @(negedge clk); rs2 = 1'b1; #1;
    vectors++; if (proto_err2 !== 1'b0) begin errors++; $display("FAIL frame_rs_clear: got %b want 0", proto_err2); end
    rs2 = 1'b0;
    send2(16'h0000, 1'b1, 4'd0);
    @(negedge clk); rd_vc2 = 4'd0; #1;
    vectors++; if ({rd_valid2, rd_new2, nonempty2[0], proto_err2, misroute2} !== 5'b11100) begin errors++; $display("FAIL frame_hdr_ok: got %b want 11100", {rd_valid2, rd_new2, nonempty2[0], proto_err2, misroute2}); end
    pop2(4'd0);
    // FIFO empty but VC0 sits at p=1.
    vectors++; if ({nonempty2, busy2} !== {13'h0, 1'b1}) begin errors++; $display("FAIL frame_midflit_busy: got %h want 0001", {nonempty2, busy2}); end
    send2(16'h0000, 1'b1, 4'd0);
    vectors++; if ({proto_err2, nonempty2} !== {1'b1, 13'h0}) begin errors++; $display("FAIL frame_hdr_p1_drop: got %h want 1 and empty", {proto_err2, nonempty2}); end
  endtask

  task automatic test_invalid_and_reset();
    @(negedge clk);
    l1.link_vc_no_in = 4'd13; l1.link_data_in = 16'h0005; l1.link_new_in = 1'b1;
    l1.link_sent_req_in = 1'b1; #1;
    vectors++; if (l1.link_ready_out !== 1'b0) begin errors++; $display("FAIL inv_ready: got %b want 0", l1.link_ready_out); end
    @(posedge clk); #1;
    l1.link_sent_req_in = 1'b0;
    vectors++; if (nonempty !== 13'h0) begin errors++; $display("FAIL inv_nothing_stored: got %h want 0", nonempty); end
    send1(16'h0005, 1'b1, 4'd0);
    send1(16'h0BAD, 1'b0, 4'd0);
    @(negedge clk); rd_vc = 4'd13; #1;
    vectors++; if ({nonempty, rd_valid, rd_data} !== {13'h1, 17'h0}) begin errors++; $display("FAIL inv_rd_zero: got %h want 1 and rd 0", {nonempty, rd_valid, rd_data}); end
    @(posedge clk); #3;
    rs = 1'b1; l1.link_vc_no_in = 4'd0; #1;
    vectors++; if ({nonempty, busy, misroute, proto_err} !== 16'h0) begin errors++; $display("FAIL rstmid_clear: got %h want 0", {nonempty, busy, misroute, proto_err}); end
    vectors++; if (l1.link_ready_out !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", l1.link_ready_out); end
    @(negedge clk); rs = 1'b0;
    // State returned to IDLE: a body phit is now a framing error.
    send1(16'h1234, 1'b0, 4'd0);
    vectors++; if ({proto_err, nonempty} !== {1'b1, 13'h0}) begin errors++; $display("FAIL rstmid_idle: got %h want 1 and empty", {proto_err, nonempty}); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rs = 1'b1; rs2 = 1'b1;
    rd_vc = '0; rd_en = 1'b0; my_addr = '0;
    rd_vc2 = '0; rd_en2 = 1'b0; my_addr2 = '0;
    l1.link_data_in = '0; l1.link_sent_req_in = 1'b0; l1.link_new_in = 1'b0; l1.link_vc_no_in = '0;
    l2.link_data_in = '0; l2.link_sent_req_in = 1'b0; l2.link_new_in = 1'b0; l2.link_vc_no_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rs = 1'b0; rs2 = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_misroute();
    test_framing();
    test_invalid_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
